// File: rtl/z80_trace_pkg.sv
// Shared types for the tv80s bus tracer: cycle types, trace record, strobe classifier.
// Record carries a timestamp field only when TRACER_TIMESTAMP_EN is defined.
package z80_trace_pkg;

  localparam int unsigned TRACE_TYPE_W = 3;

  // Bit positions inside the packed strobe sample {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n}
  localparam int unsigned STB_M1   = 5;
  localparam int unsigned STB_MREQ = 4;
  localparam int unsigned STB_IORQ = 3;
  localparam int unsigned STB_RD   = 2;
  localparam int unsigned STB_WR   = 1;
  localparam int unsigned STB_RFSH = 0;

  typedef enum logic [TRACE_TYPE_W-1:0] {
    FETCH   = 3'd0,
    MEMRD   = 3'd1,
    MEMWR   = 3'd2,
    IORD    = 3'd3,
    IOWR    = 3'd4,
    REFRESH = 3'd5,
    INTACK  = 3'd6,
    NONE    = 3'd7
  } trace_type_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_EMIT
  } trc_state_t;

  typedef struct packed {
    trace_type_t ttype;
    logic [15:0] addr;
    logic [7:0]  data;
`ifdef TRACER_TIMESTAMP_EN
    logic [15:0] tstamp;
`endif
  } trace_rec_t;

  function automatic trace_type_t classify(input logic [5:0] s);
    trace_type_t t;
    if (!s[STB_M1] && !s[STB_IORQ])                        t = INTACK;
    else if (!s[STB_M1] && !s[STB_MREQ] && !s[STB_RD])     t = FETCH;
    else if (!s[STB_RFSH] && !s[STB_MREQ])                 t = REFRESH;
    else if (!s[STB_MREQ] && !s[STB_RD])                   t = MEMRD;
    else if (!s[STB_MREQ] && !s[STB_WR])                   t = MEMWR;
    else if (!s[STB_IORQ] && !s[STB_RD])                   t = IORD;
    else if (!s[STB_IORQ] && !s[STB_WR])                   t = IOWR;
    else                                                   t = NONE;
    return t;
  endfunction

  function automatic logic [7:0] capture_data(input trace_type_t t,
                                              input logic [7:0] di,
                                              input logic [7:0] dout);
    logic [7:0] d;
    case (t)
      MEMWR, IOWR: d = dout;
      REFRESH:     d = 8'h00;
      NONE:        d = 8'h00;
      default:     d = di;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead synchronous FIFO of trace records with occupancy and a drop pulse
// for pushes refused while full (a simultaneous pop frees the slot).
module trace_fifo
  import z80_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  trace_rec_t               wdata,
  input  logic                     pop,
  output trace_rec_t               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  trace_rec_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  always_comb begin
    empty    = (level_q == '0);
    full     = (level_q == FULL_LVL);
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    drop     = push & full & ~do_pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      level_d = level_q + 1'b1;
    else if (do_pop && !do_push) level_d = level_q - 1'b1;
    rdata = empty ? '0 : mem_q[rd_ptr_q];
    level = level_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/z80_bus_tracer.sv
// Passive tv80s bus monitor: classifies each completed bus cycle and queues one record.
// Optional per-record timestamp port rec_time when TRACER_TIMESTAMP_EN is defined.
module z80_bus_tracer
  import z80_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNTW  = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic                     m1_n,
  input  logic                     mreq_n,
  input  logic                     iorq_n,
  input  logic                     rd_n,
  input  logic                     wr_n,
  input  logic                     rfsh_n,
  input  logic [15:0]              A,
  input  logic [7:0]               di,
  input  logic [7:0]               dout,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [TRACE_TYPE_W-1:0]  rec_type,
  output logic [15:0]              rec_addr,
  output logic [7:0]               rec_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNTW-1:0]          drop_cnt
`ifdef TRACER_TIMESTAMP_EN
  ,
  output logic [15:0]              rec_time
`endif
);

  logic [5:0]   s_strb_q, s_strb_d;
  logic [15:0]  s_addr_q, s_addr_d;
  logic [7:0]   s_di_q, s_di_d;
  logic [7:0]   s_dout_q, s_dout_d;
  logic         s_en_q, s_en_d;

  trc_state_t   state_q, state_d;
  trace_type_t  lat_q, lat_d;
  logic [15:0]  cap_addr_q, cap_addr_d;
  logic [7:0]   cap_data_q, cap_data_d;
  logic         overflow_q, overflow_d;
  logic [CNTW-1:0] drop_cnt_q, drop_cnt_d;

  trace_type_t  s_type;
  logic         push, start, capture;
  trace_rec_t   push_rec, head_rec;
  logic         fifo_full, fifo_empty, fifo_drop;

`ifdef TRACER_TIMESTAMP_EN
  logic [15:0]  ts_q, ts_d;

  always_comb ts_d = ts_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ts_q <= '0;
    else          ts_q <= ts_d;
  end
`endif

  always_comb begin
    s_strb_d = {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n};
    s_addr_d = A;
    s_di_d   = di;
    s_dout_d = dout;
    s_en_d   = en;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_strb_q <= '1;
      s_addr_q <= '0;
      s_di_q   <= '0;
      s_dout_q <= '0;
      s_en_q   <= 1'b0;
    end else begin
      s_strb_q <= s_strb_d;
      s_addr_q <= s_addr_d;
      s_di_q   <= s_di_d;
      s_dout_q <= s_dout_d;
      s_en_q   <= s_en_d;
    end
  end

  // FETCH followed directly by REFRESH pushes from ACTIVE so the refresh is not lost
  // while the fetch record goes out; every other type change passes through EMIT.
  always_comb begin
    s_type     = classify(s_strb_q);
    state_d    = state_q;
    lat_d      = lat_q;
    cap_addr_d = cap_addr_q;
    cap_data_d = cap_data_q;
    push       = 1'b0;
    start      = 1'b0;
    capture    = 1'b0;
    case (state_q)
      ST_IDLE: start = s_en_q && (s_type != NONE);
      ST_ACTIVE: begin
        if (!s_en_q) begin
          state_d = ST_IDLE;
        end else if (s_type == lat_q) begin
          capture = 1'b1;
        end else if (lat_q == FETCH && s_type == REFRESH) begin
          push  = 1'b1;
          start = 1'b1;
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        push    = 1'b1;
        start   = s_en_q && (s_type != NONE);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (start) begin
      state_d = ST_ACTIVE;
      lat_d   = s_type;
      capture = 1'b1;
    end
    if (capture) begin
      cap_addr_d = s_addr_q;
      cap_data_d = capture_data(s_type, s_di_q, s_dout_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      lat_q      <= NONE;
      cap_addr_q <= '0;
      cap_data_q <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      cap_addr_q <= cap_addr_d;
      cap_data_q <= cap_data_d;
    end
  end

  always_comb begin
    push_rec       = '0;
    push_rec.ttype = lat_q;
    push_rec.addr  = cap_addr_q;
    push_rec.data  = cap_data_q;
`ifdef TRACER_TIMESTAMP_EN
    push_rec.tstamp = ts_q;
`endif
  end

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (push_rec),
    .pop     (rec_ready),
    .rdata   (head_rec),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level),
    .drop    (fifo_drop)
  );

  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (fifo_drop && fifo_full) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    rec_valid = ~fifo_empty;
    rec_type  = head_rec.ttype;
    rec_addr  = head_rec.addr;
    rec_data  = head_rec.data;
    overflow  = overflow_q;
    drop_cnt  = drop_cnt_q;
`ifdef TRACER_TIMESTAMP_EN
    rec_time  = head_rec.tstamp;
`endif
  end

endmodule

// File: tb/tb_z80_bus_tracer.sv
// Randomized bus-cycle bench for z80_bus_tracer with a record-level scoreboard model.
module tb_z80_bus_tracer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNTW  = 8;

  localparam logic [2:0] T_FETCH = 3'd0, T_MEMRD = 3'd1, T_MEMWR = 3'd2, T_IORD = 3'd3;
  localparam logic [2:0] T_IOWR = 3'd4, T_REFRESH = 3'd5, T_INTACK = 3'd6, T_NONE = 3'd7;
  localparam logic [5:0] STB_IDLE = 6'b111111;

  logic clk = 1'b0;
  logic reset_n, en, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
  logic [15:0] A;
  logic [7:0]  di, dout;
  logic        rec_valid, rec_ready, overflow;
  logic [2:0]  rec_type;
  logic [15:0] rec_addr;
  logic [7:0]  rec_data;
  logic [$clog2(DEPTH):0] level;
  logic [CNTW-1:0] drop_cnt;
`ifdef TRACER_TIMESTAMP_EN
  logic [15:0] rec_time;
  logic [15:0] prev_time;
  bit          have_time = 1'b0;
`endif

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  int unsigned rdy_pct = 0;
  int unsigned model_cap = 0;
  int unsigned model_drops = 0;
  logic [26:0] exp_q[$];
  logic [26:0] got;

  always #5 clk = ~clk;

  z80_bus_tracer #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .reset_n(reset_n), .en(en),
    .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
    .A(A), .di(di), .dout(dout),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_type(rec_type), .rec_addr(rec_addr), .rec_data(rec_data),
    .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
`ifdef TRACER_TIMESTAMP_EN
    , .rec_time(rec_time)
`endif
  );

  // Strobe pattern {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n} for a canonical cycle of type t
  function automatic logic [5:0] stb_of(input logic [2:0] t);
    case (t)
      T_FETCH:   return 6'b001011;
      T_MEMRD:   return 6'b101011;
      T_MEMWR:   return 6'b101101;
      T_IORD:    return 6'b110011;
      T_IOWR:    return 6'b110101;
      T_REFRESH: return 6'b101110;
      T_INTACK:  return 6'b010111;
      default:   return STB_IDLE;
    endcase
  endfunction

  function automatic logic [2:0] type_of(input logic [5:0] s);
    logic m1, mq, io, rd, wr, rf;
    {m1, mq, io, rd, wr, rf} = ~s;
    if (m1 && io)       return T_INTACK;
    if (m1 && mq && rd) return T_FETCH;
    if (rf && mq)       return T_REFRESH;
    if (mq && rd)       return T_MEMRD;
    if (mq && wr)       return T_MEMWR;
    if (io && rd)       return T_IORD;
    if (io && wr)       return T_IOWR;
    return T_NONE;
  endfunction

  function automatic logic [7:0] data_of(input logic [2:0] t, input logic [7:0] r, input logic [7:0] w);
    if (t == T_MEMWR || t == T_IOWR) return w;
    if (t == T_REFRESH) return 8'h00;
    return r;
  endfunction

  task automatic model_emit(input logic [26:0] r);
    if (model_cap != 0 && exp_q.size() >= model_cap) model_drops++;
    else exp_q.push_back(r);
  endtask

  // One clock of pin activity; any record handed over this clock is scored at negedge.
  task automatic drive(input logic [5:0] s, input logic en_v);
    {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n} = s;
    en = en_v;
    A = 16'($urandom);
    di = 8'($urandom);
    dout = 8'($urandom);
    rec_ready = ($urandom_range(99) < rdy_pct);
    @(negedge clk);
    if (reset_n && rec_valid && rec_ready) begin
      got = {rec_type, rec_addr, rec_data};
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record got=%h required=none", got);
      end else begin
        if (got !== exp_q[0]) begin
          errors++;
          $display("FAIL record got=%h required=%h", got, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
`ifdef TRACER_TIMESTAMP_EN
      if (have_time) begin
        vectors++;
        if (rec_time == prev_time || 16'(rec_time - prev_time) >= 16'h8000) begin
          errors++;
          $display("FAIL rec_time got=%h required=after %h", rec_time, prev_time);
        end
      end
      prev_time = rec_time;
      have_time = 1'b1;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic bus_cycle(input logic [2:0] t, input int unsigned len, input int unsigned gap);
    for (int unsigned i = 0; i < len; i++) drive(stb_of(t), 1'b1);
    model_emit({t, A, data_of(t, di, dout)});
    for (int unsigned i = 0; i < gap; i++) drive(STB_IDLE, 1'b1);
  endtask

  task automatic drain();
    rdy_pct = 100;
    for (int unsigned i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !rec_valid) break;
      drive(STB_IDLE, 1'b1);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_missing got=%0d outstanding required=0", exp_q.size());
    end
    exp_q.delete();
    vectors++;
    if (level !== '0) begin
      errors++;
      $display("FAIL drain_level got=%0d required=0", level);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rdy_pct = 0;
    repeat (3) drive(stb_of(T_MEMRD), 1'b1);
    vectors += 7;
    if (rec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b required=0", rec_valid); end
    if (level !== '0)       begin errors++; $display("FAIL reset_level got=%0d required=0", level); end
    if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow got=%b required=0", overflow); end
    if (drop_cnt !== '0)    begin errors++; $display("FAIL reset_drop_cnt got=%0d required=0", drop_cnt); end
    if (rec_type !== '0)    begin errors++; $display("FAIL reset_type got=%0d required=0", rec_type); end
    if (rec_addr !== '0)    begin errors++; $display("FAIL reset_addr got=%h required=0", rec_addr); end
    if (rec_data !== '0)    begin errors++; $display("FAIL reset_data got=%h required=0", rec_data); end
    drive(STB_IDLE, 1'b1);
    reset_n = 1'b1;
    repeat (2) drive(STB_IDLE, 1'b1);
  endtask

  task automatic test_latency();
    rdy_pct = 0;
    bus_cycle(T_MEMRD, 2, 1);
    drive(STB_IDLE, 1'b1);
    vectors++;
    if (rec_valid !== 1'b0) begin errors++; $display("FAIL latency_early got=%b required=0", rec_valid); end
    drive(STB_IDLE, 1'b1);
    vectors += 2;
    if (rec_valid !== 1'b1) begin errors++; $display("FAIL latency_valid got=%b required=1", rec_valid); end
    if (level !== 5'd1)     begin errors++; $display("FAIL latency_level got=%0d required=1", level); end
    drain();
  endtask

  task automatic test_random();
    logic [2:0] t;
    rdy_pct = 70;
    for (int i = 0; i < 60; i++) begin
      t = 3'($urandom_range(6));
      if (t == T_FETCH && $urandom_range(1) == 1) begin
        bus_cycle(T_FETCH, $urandom_range(1, 3), 0);
        bus_cycle(T_REFRESH, $urandom_range(1, 2), $urandom_range(1, 2));
      end else begin
        bus_cycle(t, $urandom_range(1, 3), $urandom_range(1, 2));
      end
    end
    drain();
  endtask

  task automatic test_priority();
    logic [5:0] s;
    logic [2:0] t;
    rdy_pct = 100;
    for (int i = 0; i < 40; i++) begin
      s = 6'($urandom_range(63));
      t = type_of(s);
      drive(s, 1'b1);
      if (t != T_NONE) model_emit({t, A, data_of(t, di, dout)});
      drive(STB_IDLE, 1'b1);
    end
    drain();
  endtask

  task automatic test_full_pop();
    rdy_pct = 0;
    for (int i = 0; i < 16; i++) bus_cycle(T_MEMRD, 1, 1);
    repeat (2) drive(STB_IDLE, 1'b1);
    vectors++;
    if (level !== 5'd16) begin errors++; $display("FAIL full_level got=%0d required=16", level); end
    bus_cycle(T_IOWR, 1, 1);
    drive(STB_IDLE, 1'b1);
    rdy_pct = 100;
    drive(STB_IDLE, 1'b1);
    rdy_pct = 0;
    drive(STB_IDLE, 1'b1);
    vectors += 3;
    if (level !== 5'd16)   begin errors++; $display("FAIL full_pop_level got=%0d required=16", level); end
    if (drop_cnt !== '0)   begin errors++; $display("FAIL full_pop_drop got=%0d required=0", drop_cnt); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL full_pop_overflow got=%b required=0", overflow); end
    drain();
  endtask

  task automatic test_overflow();
    rdy_pct = 0;
    model_cap = DEPTH;
    for (int i = 0; i < 20; i++) bus_cycle(3'($urandom_range(4)), $urandom_range(1, 2), 1);
    repeat (3) drive(STB_IDLE, 1'b1);
    vectors += 3;
    if (level !== 5'd16)               begin errors++; $display("FAIL ovf_level got=%0d required=16", level); end
    if (overflow !== 1'b1)             begin errors++; $display("FAIL ovf_flag got=%b required=1", overflow); end
    if (drop_cnt !== CNTW'(model_drops)) begin errors++; $display("FAIL ovf_drop_cnt got=%0d required=%0d", drop_cnt, model_drops); end
    model_cap = 0;
    drain();
  endtask

  task automatic test_saturate();
    rdy_pct = 0;
    model_cap = DEPTH;
    for (int i = 0; i < 280; i++) bus_cycle(T_MEMWR, 1, 1);
    repeat (3) drive(STB_IDLE, 1'b1);
    vectors += 2;
    if (drop_cnt !== CNTW'(model_drops > 255 ? 255 : model_drops)) begin
      errors++; $display("FAIL sat_drop_cnt got=%0d required=%0d", drop_cnt, model_drops > 255 ? 255 : model_drops);
    end
    if (overflow !== 1'b1) begin errors++; $display("FAIL sat_overflow got=%b required=1", overflow); end
    model_cap = 0;
    drain();
  endtask

  task automatic test_en();
    rdy_pct = 100;
    drive(stb_of(T_FETCH), 1'b1);
    drive(stb_of(T_FETCH), 1'b0);
    drive(stb_of(T_FETCH), 1'b0);
    drive(STB_IDLE, 1'b1);
    bus_cycle(T_MEMRD, 2, 1);
    drive(stb_of(T_MEMWR), 1'b0);
    drive(stb_of(T_MEMWR), 1'b0);
    drive(STB_IDLE, 1'b0);
    bus_cycle(T_IORD, 1, 2);
    drain();
  endtask

  task automatic test_reset_mid();
    rdy_pct = 0;
    for (int i = 0; i < 5; i++) bus_cycle(T_FETCH, 2, 1);
    repeat (2) drive(STB_IDLE, 1'b1);
    vectors++;
    if (level !== 5'd5) begin errors++; $display("FAIL mid_level_pre got=%0d required=5", level); end
    drive(stb_of(T_MEMRD), 1'b1);
    drive(stb_of(T_MEMRD), 1'b1);
    #2 reset_n = 1'b0;
    #1;
    vectors += 4;
    if (rec_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b required=0", rec_valid); end
    if (level !== '0)       begin errors++; $display("FAIL mid_level got=%0d required=0", level); end
    if (overflow !== 1'b0)  begin errors++; $display("FAIL mid_overflow got=%b required=0", overflow); end
    if (drop_cnt !== '0)    begin errors++; $display("FAIL mid_drop_cnt got=%0d required=0", drop_cnt); end
    exp_q.delete();
    model_drops = 0;
`ifdef TRACER_TIMESTAMP_EN
    have_time = 1'b0;
`endif
    drive(STB_IDLE, 1'b1);
    reset_n = 1'b1;
    drive(STB_IDLE, 1'b1);
    bus_cycle(T_IORD, 2, 1);
    bus_cycle(T_INTACK, 1, 1);
    drain();
  endtask

  initial begin
    reset_n = 1'b0;
    en = 1'b0;
    rec_ready = 1'b0;
    {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n} = STB_IDLE;
    A = '0;
    di = '0;
    dout = '0;
    test_reset();
    test_latency();
    test_random();
    test_priority();
    test_full_pop();
    test_overflow();
    test_saturate();
    test_en();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
